gpio_irq_ctrl: RTL

Bus-side controller for the 32-bit GPIO port in the MIPS SoC. It decodes CPU word writes into the GPIO's data/strobe inputs (direction, output, output-toggle) and keeps shadow copies for readback. It also samples the GPIO's registered input word on a programmable prescaler tick and latches per-pin edge events into a pending register, producing one level interrupt to the CPU. It sits between the data-memory bus decode and the GPIO instance.

---
 rtl/gpio_pkg.sv | 20 ++
 rtl/gpio_edge_sampler.sv | 51 +++++
 rtl/gpio_irq_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO bus-side controller: register map indices,
// pin count and prescaler width.
package gpio_pkg;

  localparam int PIN_COUNT = 32;
  localparam int PRESC_W   = 16;
  localparam int ADDR_W    = 3;

  typedef enum logic [ADDR_W-1:0] {
    REG_DIR     = 3'd0,
    REG_OUT     = 3'd1,
    REG_IN      = 3'd2,
    REG_IEN     = 3'd3,
    REG_EDGE    = 3'd4,
    REG_PEND    = 3'd5,
    REG_PRESC   = 3'd6,
    REG_OUT_TGL = 3'd7
  } gpio_reg_e;

endpackage

// File: rtl/gpio_edge_sampler.sv
// Prescaled input sampler: samples the GPIO input word on each prescaler tick
// and reports per-pin edge events against the previous sample.
module gpio_edge_sampler
  import gpio_pkg::*;
(
  input  logic                 i_Clk,
  input  logic                 i_rst_n,
  input  logic [PRESC_W-1:0]   presc,
  input  logic                 presc_wr,
  input  logic [PIN_COUNT-1:0] edge_sel,
  input  logic [PIN_COUNT-1:0] din,
  output logic [PIN_COUNT-1:0] evt
);

  logic [PRESC_W-1:0]   cnt;
  logic [PIN_COUNT-1:0] smp;
  logic                 valid;
  logic                 tick;

  assign tick = (cnt == presc);

  // Clearing on a PRESC write keeps a shrinking period from wrapping through 65535.
  always_ff @(posedge i_Clk) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (presc_wr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PRESC_W'(1);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_rst_n) begin
      smp   <= '0;
      valid <= 1'b0;
    end else if (tick) begin
      smp   <= din;
      valid <= 1'b1;
    end
  end

  // The first tick after reset only primes SMP, so pins already high raise nothing.
  always_comb begin
    evt = '0;
    if (tick && valid) begin
      evt = (edge_sel & din & ~smp) | (~edge_sel & ~din & smp);
    end
  end

endmodule

// File: rtl/gpio_irq_ctrl.sv
// CPU-side register file for the 32-bit GPIO: write decode toward the GPIO,
// shadow readback, edge-pending latch and the level interrupt.
module gpio_irq_ctrl
  import gpio_pkg::*;
(
  input  logic                 i_Clk,
  input  logic                 i_rst_n,
  input  logic [ADDR_W-1:0]    i_Addr,
  input  logic [PIN_COUNT-1:0] i_WD,
  input  logic                 i_WE,
  output logic [PIN_COUNT-1:0] o_RD,
  output logic [PIN_COUNT-1:0] o_DD,
  output logic                 o_WER,
  output logic                 o_WEO,
  input  logic [PIN_COUNT-1:0] i_DIN,
  output logic                 o_Irq
);

  gpio_reg_e            reg_sel;
  logic [PIN_COUNT-1:0] dir_q;
  logic [PIN_COUNT-1:0] out_q;
  logic [PIN_COUNT-1:0] ien_q;
  logic [PIN_COUNT-1:0] edge_q;
  logic [PIN_COUNT-1:0] pend_q;
  logic [PRESC_W-1:0]   presc_q;
  logic                 irq_q;

  logic wr_dir, wr_out, wr_ien, wr_edge, wr_pend, wr_presc, wr_tgl;
  logic [PIN_COUNT-1:0] out_tgl;
  logic [PIN_COUNT-1:0] w1c_mask;
  logic [PIN_COUNT-1:0] evt;
  logic [PIN_COUNT-1:0] pend_next;

  assign reg_sel = gpio_reg_e'(i_Addr);

  always_comb begin
    wr_dir   = 1'b0;
    wr_out   = 1'b0;
    wr_ien   = 1'b0;
    wr_edge  = 1'b0;
    wr_pend  = 1'b0;
    wr_presc = 1'b0;
    wr_tgl   = 1'b0;
    if (i_WE) begin
      unique case (reg_sel)
        REG_DIR:     wr_dir   = 1'b1;
        REG_OUT:     wr_out   = 1'b1;
        REG_IN:      ;
        REG_IEN:     wr_ien   = 1'b1;
        REG_EDGE:    wr_edge  = 1'b1;
        REG_PEND:    wr_pend  = 1'b1;
        REG_PRESC:   wr_presc = 1'b1;
        REG_OUT_TGL: wr_tgl   = 1'b1;
        default:     ;
      endcase
    end
  end

  // Toggle uses the shadow, so back-to-back toggles see the first one's result.
  assign out_tgl = out_q ^ i_WD;
  assign o_DD    = wr_tgl ? out_tgl : i_WD;
  assign o_WER   = wr_dir;
  assign o_WEO   = wr_out | wr_tgl;

  gpio_edge_sampler u_sampler (
    .i_Clk    (i_Clk),
    .i_rst_n  (i_rst_n),
    .presc    (presc_q),
    .presc_wr (wr_presc),
    .edge_sel (edge_q),
    .din      (i_DIN),
    .evt      (evt)
  );

  // A new event on a bit wins over a W1C of that bit in the same cycle.
  assign w1c_mask  = wr_pend ? i_WD : '0;
  assign pend_next = (pend_q & ~w1c_mask) | evt;

  always_ff @(posedge i_Clk) begin
    if (!i_rst_n) begin
      dir_q   <= '0;
      out_q   <= '0;
      ien_q   <= '0;
      edge_q  <= '0;
      presc_q <= '0;
    end else begin
      if (wr_dir)   dir_q   <= i_WD;
      if (wr_out)   out_q   <= i_WD;
      if (wr_tgl)   out_q   <= out_tgl;
      if (wr_ien)   ien_q   <= i_WD;
      if (wr_edge)  edge_q  <= i_WD;
      if (wr_presc) presc_q <= i_WD[PRESC_W-1:0];
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_rst_n) begin
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      pend_q <= pend_next;
      irq_q  <= |(pend_q & ien_q);
    end
  end

  assign o_Irq = irq_q;

  always_comb begin
    o_RD = '0;
    unique case (reg_sel)
      REG_DIR:     o_RD = dir_q;
      REG_OUT:     o_RD = out_q;
      REG_IN:      o_RD = i_DIN;
      REG_IEN:     o_RD = ien_q;
      REG_EDGE:    o_RD = edge_q;
      REG_PEND:    o_RD = pend_q;
      REG_PRESC:   o_RD = PIN_COUNT'(presc_q);
      REG_OUT_TGL: o_RD = '0;
      default:     o_RD = '0;
    endcase
  end

endmodule
